// File: rtl/voice_mixer_if.sv
// BRAM read port and mixed-sample output bundle between voice_mixer and its neighbours.
// master = mixer side, slave = wavetable BRAM / DAC side.
interface voice_mixer_if #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH  = 5
);
  logic                           bram_en_out;
  logic [ADDR_WIDTH-1:0]          bram_addr_out;
  logic signed [SAMPLE_WIDTH-1:0] bram_data_in;
  logic signed [SAMPLE_WIDTH-1:0] sample_out;
  logic                           sample_valid_out;
  logic [COUNT_WIDTH-1:0]         voice_count_out;

  modport master (
    output bram_en_out, bram_addr_out, sample_out, sample_valid_out, voice_count_out,
    input  bram_data_in
  );

  modport slave (
    input  bram_en_out, bram_addr_out, sample_out, sample_valid_out, voice_count_out,
    output bram_data_in
  );
endinterface

// File: rtl/voice_mixer.sv
// Per-tick voice mixer: snapshots note addresses, reads one wavetable sample per active
// note, accumulates, then emits one shifted and saturated mixed sample per tick.
module voice_mixer #(
  parameter int unsigned NUM_NOTES    = 24,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned BRAM_LATENCY = 2,
  parameter int unsigned MIX_SHIFT    = 3
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                sample_tick_in,
  input  logic [NUM_NOTES-1:0][ADDR_WIDTH-1:0] addr_in,
  input  logic [NUM_NOTES-1:0]                active_voices_in,
  voice_mixer_if.master                       mix_bus,
  output logic                                busy_out,
  output logic                                overrun_out
);

  localparam int unsigned ACC_WIDTH   = SAMPLE_WIDTH + 5;
  localparam int unsigned EXT_WIDTH   = ACC_WIDTH - SAMPLE_WIDTH;
  localparam int unsigned IDX_WIDTH   = $clog2(NUM_NOTES);
  localparam int unsigned DRAIN_WIDTH = $clog2(BRAM_LATENCY) + 1;
  localparam int unsigned COUNT_WIDTH = 5;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, NORM} state_t;

  state_t                               state;
  logic [NUM_NOTES-1:0][ADDR_WIDTH-1:0] snap_addr;
  logic [NUM_NOTES-1:0]                 snap_active;
  logic [IDX_WIDTH-1:0]                 idx;
  logic [DRAIN_WIDTH-1:0]               drain_cnt;
  logic [BRAM_LATENCY-1:0]              vpipe;
  logic signed [ACC_WIDTH-1:0]          acc;
  logic [COUNT_WIDTH-1:0]               voice_cnt;

  logic                                 bram_en_c;
  logic [ADDR_WIDTH-1:0]                bram_addr_c;
  logic signed [ACC_WIDTH-1:0]          acc_shift_c;
  logic signed [SAMPLE_WIDTH-1:0]       sat_c;
  logic signed [ACC_WIDTH-1:0]          data_ext_c;

  // BRAM request straight from the snapshot; inactive notes keep the address at zero
  always_comb begin
    bram_en_c   = 1'b0;
    bram_addr_c = '0;
    if (state == SCAN && snap_active[idx]) begin
      bram_en_c   = 1'b1;
      bram_addr_c = snap_addr[idx];
    end
  end

  assign mix_bus.bram_en_out   = bram_en_c;
  assign mix_bus.bram_addr_out = bram_addr_c;

  assign data_ext_c = {{EXT_WIDTH{mix_bus.bram_data_in[SAMPLE_WIDTH-1]}}, mix_bus.bram_data_in};

  // Scale and clamp the accumulated mix into the output range
  always_comb begin
    acc_shift_c = acc >>> MIX_SHIFT;
    sat_c       = acc_shift_c[SAMPLE_WIDTH-1:0];
    if (acc_shift_c > SAT_MAX) begin
      sat_c = SAT_MAX[SAMPLE_WIDTH-1:0];
    end else if (acc_shift_c < SAT_MIN) begin
      sat_c = SAT_MIN[SAMPLE_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                    <= IDLE;
      snap_addr                <= '0;
      snap_active              <= '0;
      idx                      <= '0;
      drain_cnt                <= '0;
      vpipe                    <= '0;
      acc                      <= '0;
      voice_cnt                <= '0;
      busy_out                 <= 1'b0;
      overrun_out              <= 1'b0;
      mix_bus.sample_out       <= '0;
      mix_bus.sample_valid_out <= 1'b0;
      mix_bus.voice_count_out  <= '0;
    end else begin
      mix_bus.sample_valid_out <= 1'b0;

      // Read-valid pipeline aligned with the BRAM latency
      vpipe[0] <= bram_en_c;
      for (int i = 1; i < int'(BRAM_LATENCY); i++) begin
        vpipe[i] <= vpipe[i-1];
      end

      if (vpipe[BRAM_LATENCY-1]) begin
        acc <= acc + data_ext_c;
      end

      if (sample_tick_in && state != IDLE) begin
        overrun_out <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sample_tick_in) begin
            snap_addr   <= addr_in;
            snap_active <= active_voices_in;
            acc         <= '0;
            voice_cnt   <= '0;
            idx         <= '0;
            busy_out    <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (snap_active[idx]) begin
            voice_cnt <= voice_cnt + COUNT_WIDTH'(1);
          end
          if (idx == IDX_WIDTH'(NUM_NOTES - 1)) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            idx <= idx + IDX_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_WIDTH'(BRAM_LATENCY - 1)) begin
            state <= NORM;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_WIDTH'(1);
          end
        end
        NORM: begin
          mix_bus.sample_out       <= sat_c;
          mix_bus.voice_count_out  <= voice_cnt;
          mix_bus.sample_valid_out <= 1'b1;
          busy_out                 <= 1'b0;
          state                    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
